decompose_level: RTL

- One level of the fixed-point sym4 wavelet analysis bank; the forward counterpart of the reconstruct_Lx stages.
- Runs an input sample stream through an 8-tap low-pass filter and an 8-tap high-pass filter, then decimates by 2.
- Emits one approximation coefficient and one detail coefficient for every two accepted samples.
- Levels are chained: a_out of one instance feeds x_in of the next, so input cadence can be irregular (every cycle, or every 2^k cycles).

---
 rtl/decompose_level.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/decompose_level.sv
// One level of the sym4 analysis bank: 8-tap low/high-pass FIR pair, decimated by 2.
// Fixed 4-cycle latency from the firing sample to the dout_valid strobe.
module decompose_level #(
    parameter int INTERNAL_WIDTH = 48,
    parameter int COEF_WIDTH = 25,
    parameter int COEF_FRAC = 23,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO7 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI7 = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      din_valid,
    input  logic [INTERNAL_WIDTH-1:0] x_in,
    output logic                      dout_valid,
    output logic [INTERNAL_WIDTH-1:0] a_out,
    output logic [INTERNAL_WIDTH-1:0] d_out
);

    localparam int W  = INTERNAL_WIDTH;
    localparam int PW = INTERNAL_WIDTH + COEF_WIDTH;
    localparam int SW = PW + 3;

    localparam logic signed [COEF_WIDTH-1:0] LO [8] = '{
        DEC_LO0, DEC_LO1, DEC_LO2, DEC_LO3, DEC_LO4, DEC_LO5, DEC_LO6, DEC_LO7
    };
    localparam logic signed [COEF_WIDTH-1:0] HI [8] = '{
        DEC_HI0, DEC_HI1, DEC_HI2, DEC_HI3, DEC_HI4, DEC_HI5, DEC_HI6, DEC_HI7
    };

    logic signed [W-1:0]  tap     [8];
    logic signed [PW-1:0] lo_prod [8];
    logic signed [PW-1:0] hi_prod [8];
    logic signed [SW-1:0] lo_sum_c;
    logic signed [SW-1:0] hi_sum_c;
    logic signed [SW-1:0] lo_sum;
    logic signed [SW-1:0] hi_sum;

    // Valid pipeline: fire_q -> prod_v -> sum_v -> dout_valid.
    logic phase;
    logic fire_q;
    logic prod_v;
    logic sum_v;

    // Tap line, phase and fire flag. Fire is derived only from accepted
    // samples, so any input cadence produces correctly aligned outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) tap[i] <= '0;
            phase  <= 1'b0;
            fire_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) tap[i] <= '0;
            phase  <= 1'b0;
            fire_q <= 1'b0;
        end else begin
            fire_q <= din_valid & phase;
            if (din_valid) begin
                tap[0] <= x_in;
                for (int i = 1; i < 8; i++) tap[i] <= tap[i-1];
                phase <= ~phase;
            end
        end
    end

    // Product stage: taps are stable one cycle after the firing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                lo_prod[i] <= '0;
                hi_prod[i] <= '0;
            end
        end else if (fire_q) begin
            for (int i = 0; i < 8; i++) begin
                lo_prod[i] <= PW'(tap[i]) * PW'(LO[i]);
                hi_prod[i] <= PW'(tap[i]) * PW'(HI[i]);
            end
        end
    end

    always_comb begin
        lo_sum_c = '0;
        hi_sum_c = '0;
        for (int i = 0; i < 8; i++) begin
            lo_sum_c = lo_sum_c + SW'(lo_prod[i]);
            hi_sum_c = hi_sum_c + SW'(hi_prod[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_sum <= '0;
            hi_sum <= '0;
        end else if (prod_v) begin
            lo_sum <= lo_sum_c;
            hi_sum <= hi_sum_c;
        end
    end

    // Output stage: plain bit-select is a floor shift; upper bits wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            d_out <= '0;
        end else if (sum_v && !clear) begin
            a_out <= lo_sum[COEF_FRAC+W-1:COEF_FRAC];
            d_out <= hi_sum[COEF_FRAC+W-1:COEF_FRAC];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_v     <= 1'b0;
            sum_v      <= 1'b0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            prod_v     <= 1'b0;
            sum_v      <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            prod_v     <= fire_q;
            sum_v      <= prod_v;
            dout_valid <= sum_v;
        end
    end

    // Guard and fraction bits of the sums are intentionally discarded.
    logic unused_sum_bits;
    assign unused_sum_bits = ^{lo_sum[SW-1:COEF_FRAC+W], lo_sum[COEF_FRAC-1:0],
                               hi_sum[SW-1:COEF_FRAC+W], hi_sum[COEF_FRAC-1:0]};

endmodule
